// File: rtl/output_port_arbiter.sv
// Per-output-port round-robin arbiter for the 5-port mesh router: locks a grant for one
// whole packet and steers the winner's flits onto the shared output channel.
module output_port_arbiter #(
    parameter int unsigned N_IN    = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          req,
    input  logic [N_IN-1:0]          in_val,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    output logic [N_IN-1:0]          in_ret,
    output logic [N_IN-1:0]          grant,
    output logic                     out_val,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ret,
    output logic                     busy,
    output logic                     abort
);

    localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_IN - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  flit_cnt_q, flit_cnt_d;
    logic              abort_q, abort_d;

    logic              arb_found;
    logic [SEL_W-1:0]  arb_sel;
    logic [SEL_W-1:0]  cand;
    int unsigned       idx;
    logic              transfer;
    logic [SEL_W-1:0]  ptr_after;

    // Round-robin search: rr_ptr, rr_ptr+1, ... wrapping at N_IN.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            cand = SEL_W'(idx);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    always_comb begin
        busy     = (state_q == StBusy);
        out_val  = busy & in_val[sel_q];
        out_data = busy ? in_data[32'(sel_q) * DATA_W +: DATA_W] : '0;
        in_ret   = grant_q & {N_IN{out_ret}};
        grant    = grant_q;
        abort    = abort_q;
        transfer = out_val & out_ret;
    end

    assign ptr_after = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        flit_cnt_d = flit_cnt_q;
        abort_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    state_d    = StBusy;
                    sel_d      = arb_sel;
                    grant_d    = N_IN'(1) << arb_sel;
                    flit_cnt_d = '0;
                end
            end
            StBusy: begin
                // A final transfer wins over a same-cycle req drop: normal completion.
                if (transfer && (flit_cnt_q == LAST_CNT)) begin
                    state_d    = StIdle;
                    grant_d    = '0;
                    flit_cnt_d = '0;
                    rr_ptr_d   = ptr_after;
                end else if (!req[sel_q]) begin
                    state_d    = StIdle;
                    grant_d    = '0;
                    flit_cnt_d = '0;
                    rr_ptr_d   = ptr_after;
                    abort_d    = 1'b1;
                end else if (transfer) begin
                    flit_cnt_d = flit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            flit_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            flit_cnt_q <= flit_cnt_d;
            abort_q    <= abort_d;
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: packet-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_output_port_arbiter;

    localparam int N = 5;
    localparam int PL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  in_val;
    logic [39:0] in_data;
    logic [4:0]  in_ret;
    logic [4:0]  grant;
    logic        out_val;
    logic [7:0]  out_data;
    logic        out_ret;
    logic        busy;
    logic        abort;

    int n_cmp = 0;
    int n_err = 0;

    output_port_arbiter #(
        .N_IN(5), .DATA_W(8), .PKT_LEN(4), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .in_val(in_val), .in_data(in_data),
        .in_ret(in_ret), .grant(grant), .out_val(out_val), .out_data(out_data),
        .out_ret(out_ret), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    // Sources: each input emits base + number of flits it has had accepted so far.
    logic [7:0] src [5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    assign in_data = {8'(8'h41 + src[4]), 8'(8'h31 + src[3]), 8'(8'hA1 + src[2]),
                      8'(8'h11 + src[1]), 8'(8'h01 + src[0])};

    function automatic logic [7:0] flit_of(logic [2:0] o);
        case (o)
            3'd0:    return 8'(8'h01 + src[0]);
            3'd1:    return 8'(8'h11 + src[1]);
            3'd2:    return 8'(8'hA1 + src[2]);
            3'd3:    return 8'(8'h31 + src[3]);
            default: return 8'(8'h41 + src[4]);
        endcase
    endfunction

    function automatic int rr_pick(logic [4:0] r, int p);
        for (int k = 0; k < N; k++) begin
            logic [2:0] j;
            j = 3'((p + k) % N);
            if (r[j]) return int'(j);
        end
        return -1;
    endfunction

    // Packet-level model: owner of the output (-1 = nobody), flits sent, next search start.
    int         owner = -1;
    int         ptr = 0;
    int         cnt = 0;
    logic       abort_e = 1'b0;
    logic [2:0] oi;
    logic       m_xfer;
    assign oi = 3'(owner);
    assign m_xfer = (owner >= 0) && in_val[oi] && out_ret;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= -1;
            ptr     <= 0;
            cnt     <= 0;
            abort_e <= 1'b0;
        end else if (owner < 0) begin
            abort_e <= 1'b0;
            owner   <= rr_pick(req, ptr);
            cnt     <= 0;
        end else begin
            if (m_xfer) src[oi] <= src[oi] + 8'd1;
            if (m_xfer && cnt == PL - 1) begin
                owner   <= -1;
                ptr     <= (owner + 1) % N;
                cnt     <= 0;
                abort_e <= 1'b0;
            end else if (!req[oi]) begin
                owner   <= -1;
                ptr     <= (owner + 1) % N;
                cnt     <= 0;
                abort_e <= 1'b1;
            end else begin
                abort_e <= 1'b0;
                if (m_xfer) cnt <= cnt + 1;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] delivered [$];

    always @(negedge clk) begin
        logic [4:0] eg;
        logic [4:0] er;
        logic       ev;
        logic [7:0] ed;
        eg = (owner >= 0) ? (5'b1 << oi) : 5'b0;
        er = out_ret ? eg : 5'b0;
        ev = (owner >= 0) && in_val[oi];
        ed = (owner >= 0) ? flit_of(oi) : 8'h00;
        assert ($onehot0(grant)) else $error("grant not one-hot: %b", grant);
        check("m_onehot", 32'($onehot0(grant)), 32'd1);
        check("m_grant", 32'(grant), 32'(eg));
        check("m_busy", 32'(busy), 32'(owner >= 0));
        check("m_out_val", 32'(out_val), 32'(ev));
        check("m_out_data", 32'(out_data), 32'(ed));
        check("m_in_ret", 32'(in_ret), 32'(er));
        check("m_abort", 32'(abort), 32'(abort_e));
        if (out_val && out_ret) delivered.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Entered in the first granted cycle; ends at the negedge of the following idle cycle.
    task automatic run_pkt(logic [4:0] next_req);
        repeat (PL - 1) tick();
        req = next_req;
        tick();
        neg();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [4:0] rr_exp [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

    initial begin
        rst = 1'b0; req = '0; in_val = '0; out_ret = 1'b0;
        neg();
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out", 32'({out_val, out_data, in_ret, abort}), 0);
        tick(); rst = 1'b1;

        // Single request from input 2
        tick(); req = 5'b00100; in_val = 5'b11111; out_ret = 1'b1;
        neg(); check("t1_idle", 32'(grant), 0);
        tick(); neg();
        check("t1_grant", 32'(grant), 32'b00100);
        check("t1_f1", 32'({out_val, out_data}), 32'h1A1);
        tick(); neg(); check("t1_f2", 32'(out_data), 32'hA2);
        tick(); neg(); check("t1_f3", 32'(out_data), 32'hA3);
        tick(); req = 5'b01001; neg(); check("t1_f4", 32'(out_data), 32'hA4);
        tick(); neg();
        check("t1_done", 32'({grant, busy, abort, out_val}), 0);
        check("t1_idle_data", 32'(out_data), 0);
        tick(); neg(); check("t1_ptr3", 32'(grant), 32'b01000);
        run_pkt(5'b00000);

        // Round-robin with every input requesting
        tick(); rst = 1'b0;
        neg(); check("rr_rst", 32'({grant, busy}), 0);
        tick(); rst = 1'b1;
        tick(); req = 5'b11111;
        neg(); check("rr_idle", 32'(grant), 0);
        for (int g = 0; g < 6; g++) begin
            tick(); neg(); check("rr_grant", 32'(grant), 32'(rr_exp[g]));
            if (g < 5) begin
                repeat (3) tick();
                neg(); check("rr_hold", 32'(grant), 32'(rr_exp[g]));
                tick(); neg(); check("rr_gap", 32'(grant), 0);
            end else begin
                run_pkt(5'b00000);
            end
        end

        // Back-pressure on input 1 after its second flit
        tick(); req = 5'b00010; delivered.delete();
        neg();
        tick(); neg();
        check("bp_grant", 32'(grant), 32'b00010);
        check("bp_f1", 32'(out_data), 32'h15);
        tick(); neg(); check("bp_f2", 32'(out_data), 32'h16);
        tick(); out_ret = 1'b0; neg();
        check("bp_stall_ret", 32'(in_ret), 0);
        check("bp_stall_data", 32'({out_val, out_data}), 32'h117);
        tick(); neg(); check("bp_stall2", 32'({in_ret, out_data}), 32'h017);
        tick(); neg(); check("bp_stall3", 32'({in_ret, out_data}), 32'h017);
        tick(); out_ret = 1'b1; neg();
        check("bp_resume", 32'({in_ret, out_data}), 32'h217);
        tick(); req = 5'b00000; neg(); check("bp_f4", 32'(out_data), 32'h18);
        tick(); neg(); check("bp_done", 32'({grant, abort}), 0);
        check("bp_count", 32'(delivered.size()), 4);
        if (delivered.size() == 4) begin
            check("bp_seq", 32'({delivered[0], delivered[1], delivered[2], delivered[3]}),
                  32'h15161718);
        end

        // Abort: input 3 drops req after two transfers
        tick(); req = 5'b01000; neg();
        tick(); neg();
        check("ab_grant", 32'(grant), 32'b01000);
        check("ab_f1", 32'(out_data), 32'h39);
        tick(); neg(); check("ab_f2", 32'(out_data), 32'h3A);
        tick(); req = 5'b10100; neg();
        check("ab_pre", 32'({grant, abort}), 32'b010000);
        tick(); neg();
        check("ab_pulse", 32'({abort, grant, busy}), 32'b1000000);
        tick(); neg();
        check("ab_next", 32'({abort, grant}), 32'b010000);
        run_pkt(5'b00000);

        // Final transfer coincides with req drop while others request
        tick(); req = 5'b00100; neg();
        tick(); neg(); check("sim_f1", 32'(out_data), 32'hA9);
        run_pkt(5'b00011);
        check("sim_noabort", 32'({abort, grant, busy}), 0);
        tick(); neg(); check("sim_next", 32'(grant), 32'b00001);
        check("sim_data", 32'(out_data), 32'h09);

        // Asynchronous reset during flit 2 of input 0
        tick(); neg(); check("rs_f2", 32'(out_data), 32'h0A);
        #1 rst = 1'b0;
        #1;
        check("rs_async", 32'({grant, busy, out_val, in_ret}), 0);
        check("rs_data", 32'(out_data), 0);
        req = 5'b01001;
        tick(); tick(); rst = 1'b1;
        neg(); check("rs_idle", 32'(grant), 0);
        tick(); neg();
        check("rs_regrant", 32'(grant), 32'b00001);
        check("rs_data2", 32'(out_data), 32'h0A);
        run_pkt(5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
